// File: rtl/note_tone_gen_if.sv
// Note command channel: valid/ready handshake carrying a note code and octave shift.
//   note_valid  master->slave  command valid
//   note_ready  slave->master  command slot free
//   note        master->slave  0..6 = C..B, 7..15 = rest
//   octave      master->slave  octave shift (halves the half-period per step)
interface note_tone_gen_if #(
    parameter int unsigned OCT_W = 2
) ();
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note;
    logic [OCT_W-1:0] octave;

    modport master (
        output note_valid,
        output note,
        output octave,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note,
        input  octave,
        output note_ready
    );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator fed by note/octave commands over a valid/ready channel.
// A command waits in a one-deep pending slot and is applied only at a full-period
// boundary (tone_out falling edge), so pitch changes and stops never glitch the output.
//   clk, rst    system clock, synchronous active-high reset
//   bus         note command channel (slave side)
//   note_on     level enable; 0 stops playback at the next glitch-free point
//   tone_out    50% duty square wave
//   playing     1 while in PLAY
//   div_value   active half-period in clocks; 0 when idle
module note_tone_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned FREQ_C   = 261,
    parameter int unsigned FREQ_D   = 294,
    parameter int unsigned FREQ_E   = 329,
    parameter int unsigned FREQ_F   = 349,
    parameter int unsigned FREQ_G   = 392,
    parameter int unsigned FREQ_A   = 440,
    parameter int unsigned FREQ_B   = 493,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned OCT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    note_tone_gen_if.slave       bus,
    input  logic                 note_on,
    output logic                 tone_out,
    output logic                 playing,
    output logic [CNT_W-1:0]     div_value
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(CLK_FREQ / (2 * FREQ_C));
    localparam logic [CNT_W-1:0] BASE_D = CNT_W'(CLK_FREQ / (2 * FREQ_D));
    localparam logic [CNT_W-1:0] BASE_E = CNT_W'(CLK_FREQ / (2 * FREQ_E));
    localparam logic [CNT_W-1:0] BASE_F = CNT_W'(CLK_FREQ / (2 * FREQ_F));
    localparam logic [CNT_W-1:0] BASE_G = CNT_W'(CLK_FREQ / (2 * FREQ_G));
    localparam logic [CNT_W-1:0] BASE_A = CNT_W'(CLK_FREQ / (2 * FREQ_A));
    localparam logic [CNT_W-1:0] BASE_B = CNT_W'(CLK_FREQ / (2 * FREQ_B));

    // Half-period for a note code, shifted down by the octave.
    function automatic logic [CNT_W-1:0] calc_div(input logic [3:0] n, input logic [OCT_W-1:0] o);
        logic [CNT_W-1:0] base;
        case (n)
            4'd0:    base = BASE_C;
            4'd1:    base = BASE_D;
            4'd2:    base = BASE_E;
            4'd3:    base = BASE_F;
            4'd4:    base = BASE_G;
            4'd5:    base = BASE_A;
            4'd6:    base = BASE_B;
            default: base = '0;
        endcase
        return base >> o;
    endfunction

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic             tone_nxt;
    logic             playing_nxt;
    logic             pending, pending_nxt;
    logic [3:0]       pend_note, pend_note_nxt;
    logic [OCT_W-1:0] pend_oct, pend_oct_nxt;
    logic             ready, ready_nxt;

    logic             pend_rest_c;
    logic [CNT_W-1:0] pend_div_c;
    logic             at_end_c;

    assign pend_rest_c    = (pend_note > 4'd6);
    assign pend_div_c     = calc_div(pend_note, pend_oct);
    assign at_end_c       = (counter == div_value - CNT_W'(1));
    assign bus.note_ready = ready;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            div_value <= '0;
            tone_out  <= 1'b0;
            playing   <= 1'b0;
            pending   <= 1'b0;
            pend_note <= '0;
            pend_oct  <= '0;
            ready     <= 1'b1;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            div_value <= div_nxt;
            tone_out  <= tone_nxt;
            playing   <= playing_nxt;
            pending   <= pending_nxt;
            pend_note <= pend_note_nxt;
            pend_oct  <= pend_oct_nxt;
            ready     <= ready_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt     = state;
        counter_nxt   = counter;
        div_nxt       = div_value;
        tone_nxt      = tone_out;
        pending_nxt   = pending;
        pend_note_nxt = pend_note;
        pend_oct_nxt  = pend_oct;

        case (state)
            IDLE: begin
                // A pending command waits here until note_on allows it to start.
                if (pending && note_on) begin
                    pending_nxt = 1'b0;
                    if (!pend_rest_c) begin
                        state_nxt   = PLAY;
                        div_nxt     = pend_div_c;
                        counter_nxt = '0;
                        tone_nxt    = 1'b0;
                    end
                end
            end
            PLAY: begin
                if (!tone_out && !note_on) begin
                    // Output already low: stopping now cannot glitch.
                    state_nxt   = IDLE;
                    div_nxt     = '0;
                    counter_nxt = '0;
                    pending_nxt = 1'b0;
                end else if (at_end_c) begin
                    counter_nxt = '0;
                    tone_nxt    = ~tone_out;
                    if (tone_out) begin
                        // Falling edge is the full-period boundary.
                        if (!note_on || (pending && pend_rest_c)) begin
                            state_nxt   = IDLE;
                            div_nxt     = '0;
                            pending_nxt = 1'b0;
                        end else if (pending) begin
                            div_nxt     = pend_div_c;
                            pending_nxt = 1'b0;
                        end
                    end
                end else begin
                    counter_nxt = counter + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // ready mirrors !pending, so an accept never coincides with an apply.
        if (bus.note_valid && ready) begin
            pending_nxt   = 1'b1;
            pend_note_nxt = bus.note;
            pend_oct_nxt  = bus.octave;
        end

        ready_nxt   = !pending_nxt;
        playing_nxt = (state_nxt == PLAY);
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen with CLK_FREQ=8800 (C=16, D=14, E=13, F=12, G=11, A=10, B=8).
module tb_note_tone_gen;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned OCT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             note_on;
    logic             tone_out;
    logic             playing;
    logic [CNT_W-1:0] div_value;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n;

    note_tone_gen_if #(.OCT_W(OCT_W)) bus ();

    note_tone_gen #(
        .CLK_FREQ (8800),
        .CNT_W    (CNT_W),
        .OCT_W    (OCT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .note_on   (note_on),
        .tone_out  (tone_out),
        .playing   (playing),
        .div_value (div_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int unsigned k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Offer one command for exactly one clock (slot is expected free).
    task automatic send(input logic [3:0] nt, input logic [OCT_W-1:0] oc);
        bus.note_valid = 1'b1;
        bus.note       = nt;
        bus.octave     = oc;
        tick();
        bus.note_valid = 1'b0;
    endtask

    // Count clocks tone_out stays at lvl, bounded at 100.
    task automatic count_level(input logic lvl, output int unsigned cnt);
        cnt = 0;
        while (tone_out == lvl && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst            = 1'b1;
        note_on        = 1'b0;
        bus.note_valid = 1'b0;
        bus.note       = 4'd0;
        bus.octave     = '0;
        tick();
        rst = 1'b0;
        check("rst_tone", 32'(tone_out), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_div", div_value, 0);
        check("rst_ready", 32'(bus.note_ready), 1);

        // 1: A, octave 0
        note_on = 1'b1;
        send(4'd5, 2'd0);
        check("t1_ready_low", 32'(bus.note_ready), 0);
        check("t1_div_before", div_value, 0);
        tick();
        check("t1_div", div_value, 10);
        check("t1_playing", 32'(playing), 1);
        check("t1_ready_back", 32'(bus.note_ready), 1);
        count_level(1'b0, n); check("t1_first_rise", n, 10);
        count_level(1'b1, n); check("t1_high", n, 10);
        count_level(1'b0, n); check("t1_low", n, 10);

        // 2: A, octave 1, requested one clock into a high phase
        send(4'd5, 2'd1);
        count_level(1'b1, n); check("t2_high_rest", n, 9);
        check("t2_div", div_value, 5);
        count_level(1'b0, n); check("t2_low", n, 5);
        count_level(1'b1, n); check("t2_high", n, 5);

        // 3: back to A, then switch to C during a high phase
        send(4'd5, 2'd0);
        count_level(1'b0, n); check("t3_low_rest", n, 4);
        count_level(1'b1, n); check("t3_high_old", n, 5);
        check("t3_div_a", div_value, 10);
        count_level(1'b0, n); check("t3_low_a", n, 10);
        send(4'd0, 2'd0);
        count_level(1'b1, n); check("t3_high_full", n, 9);
        check("t3_div_c", div_value, 16);
        count_level(1'b0, n); check("t3_low_c", n, 16);
        count_level(1'b1, n); check("t3_high_c", n, 16);

        // 4: rest stops at the next falling boundary
        send(4'd9, 2'd0);
        count_level(1'b0, n); check("t4_low", n, 15);
        check("t4_playing_mid", 32'(playing), 1);
        count_level(1'b1, n); check("t4_high", n, 16);
        check("t4_playing", 32'(playing), 0);
        check("t4_div", div_value, 0);
        check("t4_tone", 32'(tone_out), 0);
        check("t4_ready", 32'(bus.note_ready), 1);

        // 5a: drop note_on after three high cycles
        send(4'd5, 2'd0);
        tick();
        count_level(1'b0, n); check("t5_first_rise", n, 10);
        tick_n(3);
        note_on = 1'b0;
        count_level(1'b1, n); check("t5_high_rest", n, 7);
        check("t5_playing", 32'(playing), 0);
        check("t5_div", div_value, 0);

        // 5b: drop note_on in a low phase
        note_on = 1'b1;
        send(4'd5, 2'd0);
        tick();
        tick_n(3);
        check("t5b_playing_pre", 32'(playing), 1);
        note_on = 1'b0;
        tick();
        check("t5b_playing", 32'(playing), 0);
        check("t5b_div", div_value, 0);
        check("t5b_tone", 32'(tone_out), 0);

        // IDLE holds a pending note while note_on is low; B oct 2 gives div 2
        send(4'd6, 2'd2);
        tick_n(3);
        check("hold_ready", 32'(bus.note_ready), 0);
        check("hold_playing", 32'(playing), 0);
        note_on = 1'b1;
        tick();
        check("hold_div", div_value, 2);
        check("hold_ready_back", 32'(bus.note_ready), 1);
        count_level(1'b0, n); check("b2_low", n, 2);
        count_level(1'b1, n); check("b2_high", n, 2);

        // 6: reset mid-play with a pending command
        send(4'd0, 2'd3);
        check("t6_ready_low", 32'(bus.note_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_tone", 32'(tone_out), 0);
        check("t6_playing", 32'(playing), 0);
        check("t6_ready", 32'(bus.note_ready), 1);
        check("t6_div", div_value, 0);
        tick_n(3);
        check("t6_pending_gone", 32'(playing), 0);

        // Rest while idle clears the slot without starting
        send(4'd12, 2'd0);
        tick();
        check("idle_rest_ready", 32'(bus.note_ready), 1);
        check("idle_rest_playing", 32'(playing), 0);

        // C octave 3: 16>>3 = 2
        send(4'd0, 2'd3);
        tick();
        check("c3_div", div_value, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
